// File: rtl/btn_pkg.sv
// Shared constants for the button debouncer: PULSE_MODE encodings and
// legal parameter limits.
package btn_pkg;

  localparam int PULSE_PRESS   = 0;
  localparam int PULSE_RELEASE = 1;
  localparam int PULSE_BOTH    = 2;

  localparam int MAX_CHANNELS  = 32;
  localparam int MAX_DEB       = 65535;

endpackage

// File: rtl/btn_chan.sv
// One debouncer channel: two-flop synchroniser, a stable level, and a
// saturating counter that accepts a new level after DEB_CYCLES consecutive
// mismatching samples. Rise/fall strobes are registered with the level.
module btn_chan #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Next state: any sample matching the stable level clears the count; a run
  // of mismatches saturates at CNT_MAX, where the new level is taken and the
  // matching strobe is raised on the same edge.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset returns the channel to "released" with an empty count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/btn_debouncer.sv
// Multi-channel button debouncer top: input polarity correction, one
// btn_chan per button, pulse-mode selection, reset gating of strobes and
// an any-pressed summary.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DEB_CYCLES  = 16,
  parameter int ACTIVE_HIGH = 1,
  parameter int PULSE_MODE  = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_pulse,
  output logic            btn_any
);

  if (N_CH < 1 || N_CH > MAX_CHANNELS) begin : gen_bad_nch
    $error("btn_debouncer: N_CH out of range 1..32");
  end
  if (DEB_CYCLES < 1 || DEB_CYCLES > MAX_DEB) begin : gen_bad_deb
    $error("btn_debouncer: DEB_CYCLES out of range 1..65535");
  end
  if (ACTIVE_HIGH != 0 && ACTIVE_HIGH != 1) begin : gen_bad_pol
    $error("btn_debouncer: ACTIVE_HIGH must be 0 or 1");
  end

  logic [N_CH-1:0] btnPressed;
  logic [N_CH-1:0] riseRaw;
  logic [N_CH-1:0] fallRaw;
  logic [N_CH-1:0] pulseRaw;

  assign btnPressed = (ACTIVE_HIGH != 0) ? btn_in : ~btn_in;

  for (genvar i = 0; i < N_CH; i++) begin : gen_chan
    btn_chan #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .btn_i  (btnPressed[i]),
      .level_o(btn_level[i]),
      .rise_o (riseRaw[i]),
      .fall_o (fallRaw[i])
    );
  end

  // Pulse source selection; unknown modes fall back to press strobes.
  always_comb begin
    pulseRaw = riseRaw;
    case (PULSE_MODE)
      PULSE_RELEASE: pulseRaw = fallRaw;
      PULSE_BOTH:    pulseRaw = riseRaw | fallRaw;
      default:       pulseRaw = riseRaw;
    endcase
  end

  assign btn_rise  = riseRaw  & {N_CH{~reset}};
  assign btn_fall  = fallRaw  & {N_CH{~reset}};
  assign btn_pulse = pulseRaw & {N_CH{~reset}};
  assign btn_any   = |btn_level;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer: one active-high press-mode instance and
// one active-low both-edge instance, both with DEB_CYCLES=4.
module tb_btn_debouncer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] inA, levelA, riseA, fallA, pulseA;
  logic [3:0] inB, levelB, riseB, fallB, pulseB;
  logic       anyA, anyB;
  int         errors = 0;
  int         checks = 0;
  int         riseCount;
  logic       bounce [6];

  always #5 clock = ~clock;

  btn_debouncer #(
    .N_CH(4), .DEB_CYCLES(4), .ACTIVE_HIGH(1), .PULSE_MODE(0)
  ) dutA (
    .clock(clock), .reset(reset), .btn_in(inA), .btn_level(levelA),
    .btn_rise(riseA), .btn_fall(fallA), .btn_pulse(pulseA), .btn_any(anyA)
  );

  btn_debouncer #(
    .N_CH(4), .DEB_CYCLES(4), .ACTIVE_HIGH(0), .PULSE_MODE(2)
  ) dutB (
    .clock(clock), .reset(reset), .btn_in(inB), .btn_level(levelB),
    .btn_rise(riseB), .btn_fall(fallB), .btn_pulse(pulseB), .btn_any(anyB)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance n clock edges, returning at the following falling edge.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Drive both instances' raw button inputs.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    inA = a;
    inB = b;
  endtask

  // Directed sequence; inputs change only on falling edges.
  initial begin
    reset = 1'b1;
    applyStimulus(4'h0, 4'hF);
    @(negedge clock);
    stepCycles(3);
    checkOutput("resetLevelA", 32'(levelA), 32'h0);
    checkOutput("resetStrobeA", 32'({riseA, fallA, pulseA}), 32'h0);
    checkOutput("resetLevelB", 32'({levelB, anyB}), 32'h0);
    reset = 1'b0;
    stepCycles(3);
    checkOutput("idleA", 32'({levelA, anyA}), 32'h0);
    checkOutput("idleB", 32'({levelB, anyB}), 32'h0);

    // Single press on channel 0: level on the 6th edge, one-cycle strobe.
    inA[0] = 1'b1;
    stepCycles(5);
    checkOutput("press0Early", 32'({levelA, riseA}), 32'h0);
    stepCycles(1);
    checkOutput("press0Level", 32'(levelA), 32'h1);
    checkOutput("press0Rise", 32'(riseA), 32'h1);
    checkOutput("press0Pulse", 32'(pulseA), 32'h1);
    checkOutput("press0Any", 32'(anyA), 32'h1);
    stepCycles(1);
    checkOutput("press0RiseOff", 32'({riseA, pulseA}), 32'h0);
    checkOutput("press0Hold", 32'(levelA), 32'h1);
    inA[0] = 1'b0;
    stepCycles(5);
    checkOutput("release0Early", 32'(levelA), 32'h1);
    stepCycles(1);
    checkOutput("release0Level", 32'(levelA), 32'h0);
    checkOutput("release0Fall", 32'(fallA), 32'h1);
    checkOutput("release0Pulse", 32'(pulseA), 32'h0);
    stepCycles(1);
    checkOutput("release0FallOff", 32'(fallA), 32'h0);

    // Three-cycle glitch on channel 1 is rejected.
    inA[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) inA[1] = 1'b0;
      stepCycles(1);
      checkOutput("glitch1", 32'({levelA[1], riseA[1], fallA[1]}), 32'h0);
    end

    // Bounce 1,0,1,1,1,1 on channel 2: one press, 6 edges after the last rise.
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    riseCount = 0;
    for (int i = 0; i < 6; i++) begin
      inA[2] = bounce[i];
      stepCycles(1);
      if (riseA[2]) riseCount++;
    end
    stepCycles(1);
    checkOutput("bounce2Early", 32'(levelA[2]), 32'h0);
    if (riseA[2]) riseCount++;
    stepCycles(1);
    checkOutput("bounce2Level", 32'(levelA[2]), 32'h1);
    checkOutput("bounce2Rise", 32'(riseA), 32'h4);
    if (riseA[2]) riseCount++;
    for (int i = 0; i < 4; i++) begin
      stepCycles(1);
      if (riseA[2]) riseCount++;
    end
    checkOutput("bounce2RiseCount", 32'(riseCount), 32'd1);
    inA[2] = 1'b0;
    stepCycles(8);
    checkOutput("bounce2Released", 32'(levelA), 32'h0);

    // Active-low, both-edge instance on channel 3.
    inB[3] = 1'b0;
    stepCycles(5);
    checkOutput("b3PressEarly", 32'(levelB), 32'h0);
    stepCycles(1);
    checkOutput("b3PressLevel", 32'({levelB, anyB}), 32'h11);
    checkOutput("b3Rise", 32'({riseB, fallB}), 32'h80);
    checkOutput("b3PulseRise", 32'(pulseB), 32'h8);
    stepCycles(1);
    checkOutput("b3PulseOff", 32'({riseB, pulseB}), 32'h0);
    inB[3] = 1'b1;
    stepCycles(6);
    checkOutput("b3ReleaseLevel", 32'({levelB, anyB}), 32'h0);
    checkOutput("b3Fall", 32'({riseB, fallB}), 32'h08);
    checkOutput("b3PulseFall", 32'(pulseB), 32'h8);
    stepCycles(1);
    checkOutput("b3FallOff", 32'({fallB, pulseB}), 32'h0);

    // Reset on count 2 of a channel-0 press; input held through reset.
    inA[0] = 1'b1;
    stepCycles(4);
    reset = 1'b1;
    #1;
    checkOutput("rstGate", 32'({riseA, fallA, pulseA, levelA}), 32'h0);
    stepCycles(1);
    checkOutput("rstMid1", 32'({riseA, pulseA, levelA, anyA}), 32'h0);
    stepCycles(1);
    checkOutput("rstMid2", 32'({riseA, pulseA, levelA, anyA}), 32'h0);
    reset = 1'b0;
    stepCycles(5);
    checkOutput("rstAfterEarly", 32'({levelA, riseA}), 32'h0);
    stepCycles(1);
    checkOutput("rstAfterRise", 32'({levelA, riseA}), 32'h11);
    stepCycles(1);
    checkOutput("rstAfterRiseOff", 32'(riseA), 32'h0);
    inA[0] = 1'b0;
    stepCycles(8);
    checkOutput("rstSettled", 32'(levelA), 32'h0);

    // All four channels pressed together, then released in two groups.
    inA = 4'hF;
    stepCycles(5);
    checkOutput("allEarly", 32'({levelA, anyA}), 32'h0);
    stepCycles(1);
    checkOutput("allRise", 32'(riseA), 32'hF);
    checkOutput("allLevel", 32'({levelA, anyA}), 32'h1F);
    inA = 4'h8;
    stepCycles(6);
    checkOutput("partFall", 32'(fallA), 32'h7);
    checkOutput("partAny", 32'({levelA, anyA}), 32'h11);
    stepCycles(2);
    inA = 4'h0;
    stepCycles(5);
    checkOutput("lastHeldAny", 32'(anyA), 32'h1);
    stepCycles(1);
    checkOutput("lastFall", 32'(fallA), 32'h8);
    checkOutput("allReleasedAny", 32'({levelA, anyA}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
